// File: rtl/minifpga_pkg.sv
// minifpga_pkg: shared tile configuration sizes, sync marker and loader states
package minifpga_pkg;
  localparam int LOCMUX_CFG_BITS = 80;
  localparam int LUT_CFG_BITS = 33;
  localparam int LUTS_PER_TILE = 8;
  localparam int TILE_CFG_BITS = LOCMUX_CFG_BITS + LUTS_PER_TILE * LUT_CFG_BITS;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} ld_state_t;
endpackage

// File: rtl/minifpga_cfg_loader_if.sv
// minifpga_cfg_loader_if: byte-serial bitstream valid/ready channel
interface minifpga_cfg_loader_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master (output in_data, in_valid, input in_ready);
  modport slave (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/minifpga_cfg_loader.sv
// minifpga_cfg_loader: assembles a checksummed bitstream frame and atomically commits tile configuration
module minifpga_cfg_loader #(
  parameter int NUM_TILES = 4,
  parameter int TILE_CFG_BITS = minifpga_pkg::TILE_CFG_BITS,
  parameter logic [7:0] SYNC_BYTE = minifpga_pkg::DEF_SYNC_BYTE
) (
  input  logic clk,
  input  logic rst,
  minifpga_cfg_loader_if.slave bus,
  output logic [NUM_TILES*TILE_CFG_BITS-1:0] cfgbits,
  output logic cfg_valid,
  output logic load_busy,
  output logic load_done,
  output logic load_err
);
  import minifpga_pkg::*;
  localparam int CFG_W = NUM_TILES * TILE_CFG_BITS;
  localparam int PAYLOAD_BYTES = CFG_W / 8;
  localparam int IW = $clog2(PAYLOAD_BYTES + 1);
  ld_state_t state, state_n;
  logic [IW-1:0] idx;
  logic [7:0] acc;
  logic [CFG_W-1:0] shadow;
  logic xfer;
  assign bus.in_ready = state != COMMIT;
  assign xfer = bus.in_valid && bus.in_ready;
  assign load_busy = state == LOAD || state == CHECK;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = (xfer && bus.in_data == SYNC_BYTE) ? LOAD : IDLE;
      LOAD:    state_n = (xfer && idx == IW'(PAYLOAD_BYTES - 1)) ? CHECK : LOAD;
      CHECK:   state_n = !xfer ? CHECK : (bus.in_data == acc ? COMMIT : IDLE);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      cfgbits <= '0;
      cfg_valid <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_n;
      load_done <= state == COMMIT;
      if (xfer && state == IDLE && bus.in_data == SYNC_BYTE) begin
        idx <= '0;
        acc <= '0;
      end
      if (xfer && state == LOAD) begin
        idx <= idx + 1'b1;
        acc <= acc ^ bus.in_data;
      end
      if (xfer && state == CHECK) load_err <= bus.in_data != acc;
      if (state == COMMIT) begin
        cfgbits <= shadow;
        cfg_valid <= 1'b1;
      end
    end
  end
  // Shadow is staging only; tiles never see it until COMMIT, so it needs no reset.
  always_ff @(posedge clk) begin
    if (xfer && state == LOAD) shadow[{idx, 3'b000} +: 8] <= bus.in_data;
  end
endmodule
